// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: button sync/debounce, step prescaler and four-mode pattern sequencer.
// Optional long-press pause feature is enabled by defining LED_PATTERN_SCHED_HOLD_EN.
//
// state    | meaning
// M_COUNT  | binary up-count
// M_WALK   | single lit LED rotating left
// M_BOUNCE | single lit LED sweeping up and back down
// M_FLASH  | whole bank toggling each step
module led_pattern_sched #(
    parameter int CLK_HZ        = 24000000,
    parameter int STEP_HZ       = 8,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnx,
    output logic [8:1] ledx,
    output logic [1:0] mode,
    output logic       step_tick,
    output logic       paused
);

    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int DEB_CYC  = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int PW       = $clog2(STEP_DIV + 1);
    localparam int DW       = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {M_COUNT, M_WALK, M_BOUNCE, M_FLASH} mode_t;

    logic          sync1, sync2;
    logic          deb_level;
    logic [DW-1:0] deb_cnt;
    logic          deb_flip;
    logic          advance;
    logic [PW-1:0] presc;
    logic          presc_tc;
    mode_t         state_q, state_d;
    logic [7:0]    pattern, init_pat;
    logic          dir_up;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btnx;
            sync2 <= sync1;
        end
    end

    // Level must disagree for DEB_CYC consecutive cycles before it is accepted.
    assign deb_flip = (sync2 != deb_level) && (deb_cnt == DW'(DEB_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync2 == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_flip) begin
            deb_level <= sync2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef LED_PATTERN_SCHED_HOLD_EN
    localparam int LONG_CYC = (CLK_HZ / 1000) * LONG_PRESS_MS;
    localparam int HW       = $clog2(LONG_CYC + 1);

    logic [HW-1:0] hold_cnt;
    logic          consumed, paused_q, hold_hit, release_evt;

    assign release_evt = deb_flip && sync2;
    assign hold_hit    = !deb_level && !consumed && (hold_cnt == HW'(LONG_CYC - 1));
    assign advance     = release_evt && !consumed && !hold_hit;
    assign paused      = paused_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            consumed <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            if (deb_level)
                hold_cnt <= '0;
            else if (hold_cnt != HW'(LONG_CYC - 1))
                hold_cnt <= hold_cnt + 1'b1;
            if (release_evt)
                consumed <= 1'b0;
            else if (hold_hit)
                consumed <= 1'b1;
            if (hold_hit)
                paused_q <= !paused_q;
        end
    end
`else
    logic press;

    assign press   = deb_flip && !sync2;
    assign advance = press;
    assign paused  = 1'b0;
`endif

    assign presc_tc  = (presc == PW'(STEP_DIV - 1));
    assign step_tick = presc_tc && !paused;

    always_ff @(posedge clk) begin
        if (rst)
            presc <= '0;
        else if (advance)
            presc <= '0;
        else if (!paused)
            presc <= presc_tc ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= M_COUNT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            unique case (state_q)
                M_COUNT:  state_d = M_WALK;
                M_WALK:   state_d = M_BOUNCE;
                M_BOUNCE: state_d = M_FLASH;
                M_FLASH:  state_d = M_COUNT;
                default:  state_d = M_COUNT;
            endcase
        end
    end

    always_comb begin
        mode     = state_q;
        init_pat = 8'h00;
        unique case (state_d)
            M_COUNT:  init_pat = 8'h00;
            M_WALK:   init_pat = 8'h01;
            M_BOUNCE: init_pat = 8'h01;
            M_FLASH:  init_pat = 8'hFF;
            default:  init_pat = 8'h00;
        endcase
    end

    // A mode change outranks a coincident step: the new mode starts from its init value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= 8'h00;
            dir_up  <= 1'b1;
        end else if (advance) begin
            pattern <= init_pat;
            dir_up  <= 1'b1;
        end else if (step_tick) begin
            unique case (state_q)
                M_COUNT: pattern <= pattern + 8'h01;
                M_WALK:  pattern <= {pattern[6:0], pattern[7]};
                M_BOUNCE: begin
                    if (dir_up) begin
                        pattern <= pattern << 1;
                        if (pattern == 8'h40)
                            dir_up <= 1'b0;
                    end else begin
                        pattern <= pattern >> 1;
                        if (pattern == 8'h02)
                            dir_up <= 1'b1;
                    end
                end
                M_FLASH: pattern <= ~pattern;
                default: pattern <= pattern;
            endcase
        end
    end

    assign ledx = ~pattern;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched: directed scenarios plus random button activity,
// every cycle compared against a step-count based pattern model.
module tb_led_pattern_sched;

    localparam int STEP_DIV = 10;
    localparam int DEB_CYC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnx = 1'b1;
    logic [8:1] ledx;
    logic [1:0] mode;
    logic       step_tick;
    logic       paused;

    int checks = 0;
    int failures = 0;

    // Model: mode, steps since last load, prescaler phase, debounced button.
    int   m_mode, m_k, m_cyc, m_run;
    logic m_s1, m_s2, m_deb, m_paused;
`ifdef LED_PATTERN_SCHED_HOLD_EN
    localparam int LONG_CYC = 20;
    int   m_low;
    logic m_consumed;
`endif

    led_pattern_sched #(
        .CLK_HZ(1000),
        .STEP_HZ(100),
        .DEBOUNCE_MS(2),
        .LONG_PRESS_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btnx(btnx),
        .ledx(ledx),
        .mode(mode),
        .step_tick(step_tick),
        .paused(paused)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] pat_of(input int md, input int k);
        int idx;
        case (md)
            0: return 8'(k % 256);
            1: return 8'(1 << (k % 8));
            2: begin
                idx = k % 14;
                if (idx > 7) idx = 14 - idx;
                return 8'(1 << idx);
            end
            default: return ((k % 2) == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_run = 0;
        m_mode = 0; m_k = 0; m_cyc = 0; m_paused = 1'b0;
`ifdef LED_PATTERN_SCHED_HOLD_EN
        m_low = 0; m_consumed = 1'b0;
`endif
    endtask

    task automatic check_model();
        check("ledx", ledx, ~pat_of(m_mode, m_k));
        check("mode", {6'b0, mode}, 8'(m_mode));
        check("step_tick", {7'b0, step_tick}, {7'b0, (m_cyc == STEP_DIV - 1) && !m_paused});
        check("paused", {7'b0, paused}, {7'b0, m_paused});
    endtask

    // Drive btnx for one clock, advance the model across the edge, then compare.
    task automatic step(input logic b);
        logic s2_old, deb_old, p_old, ev_fall, ev_rise, adv, tick_now;
        btnx = b;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            s2_old = m_s2; m_s2 = m_s1; m_s1 = b;
            deb_old = m_deb; p_old = m_paused;
            ev_fall = 1'b0; ev_rise = 1'b0;
            if (s2_old != m_deb) begin
                m_run++;
                if (m_run == DEB_CYC) begin
                    m_deb = s2_old; m_run = 0;
                    ev_fall = !m_deb; ev_rise = m_deb;
                end
            end else begin
                m_run = 0;
            end
            tick_now = (m_cyc == STEP_DIV - 1) && !p_old;
`ifdef LED_PATTERN_SCHED_HOLD_EN
            if (deb_old == 1'b0) begin
                m_low++;
                if (m_low == LONG_CYC && !m_consumed) begin
                    m_paused = !m_paused; m_consumed = 1'b1;
                end
            end else begin
                m_low = 0;
            end
            adv = ev_rise && !m_consumed;
            if (ev_rise) m_consumed = 1'b0;
`else
            adv = ev_fall;
`endif
            if (adv) begin
                m_mode = (m_mode + 1) % 4; m_k = 0; m_cyc = 0;
            end else if (!p_old) begin
                m_cyc = (m_cyc + 1) % STEP_DIV;
                if (tick_now) m_k++;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] exp_walk [8];
        logic       lvl;
        exp_walk = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        model_reset();

        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        check("rst_ledx", ledx, 8'hFF);
        check("rst_mode", {6'b0, mode}, 8'h00);
        rst = 1'b0;

`ifndef LED_PATTERN_SCHED_HOLD_EN
        repeat (30) step(1'b1);
        check("count_3_ticks", ledx, 8'hFC);
        repeat (2530) step(1'b1);
        check("count_wrap", ledx, 8'hFF);

        step(1'b0);
        repeat (6) step(1'b1);
        check("glitch_mode", {6'b0, mode}, 8'h00);
        repeat (3) step(1'b0);
        check("press_not_yet", {6'b0, mode}, 8'h00);
        step(1'b0);
        check("press_mode", {6'b0, mode}, 8'h01);
        check("press_ledx", ledx, 8'hFE);

        for (int i = 0; i < 8; i++) begin
            repeat (9) step(1'b1);
            check("walk_tick", {7'b0, step_tick}, 8'h01);
            step(1'b1);
            check("walk_ledx", ledx, exp_walk[i]);
        end

        repeat (4) step(1'b0);
        check("bounce_mode", {6'b0, mode}, 8'h02);
        check("bounce_init", ledx, 8'hFE);
        for (int i = 1; i <= 14; i++) begin
            repeat (10) step(1'b1);
            if (i == 7) check("bounce_top", ledx, 8'h7F);
        end
        check("bounce_back", ledx, 8'hFE);

        repeat (5) step(1'b1);
        for (int n = 0; n < 20 && m_cyc != 6; n++) step(1'b1);
        repeat (3) step(1'b0);
        check("coincide_tick", {7'b0, step_tick}, 8'h01);
        step(1'b0);
        check("coincide_mode", {6'b0, mode}, 8'h03);
        check("coincide_init", ledx, 8'h00);

        repeat (6) step(1'b1);
        repeat (4) step(1'b0);
        check("wrap_mode", {6'b0, mode}, 8'h00);
        check("wrap_ledx", ledx, 8'hFF);

        repeat (31) step(1'b1);
        repeat (2) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        check("mid_rst_ledx", ledx, 8'hFF);
        check("mid_rst_mode", {6'b0, mode}, 8'h00);
        check("mid_rst_tick", {7'b0, step_tick}, 8'h00);
        step(1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0);
        check("held_rst_wait", {6'b0, mode}, 8'h00);
        step(1'b0);
        check("held_rst_mode", {6'b0, mode}, 8'h01);
        check("held_rst_ledx", ledx, 8'hFE);
`else
        repeat (15) step(1'b1);
        repeat (30) step(1'b0);
        check("hold_paused", {7'b0, paused}, 8'h01);
        check("hold_mode", {6'b0, mode}, 8'h00);
        check("hold_ledx", ledx, 8'hFC);
        repeat (20) step(1'b1);
        check("frozen_ledx", ledx, 8'hFC);
        check("frozen_mode", {6'b0, mode}, 8'h00);
        repeat (6) step(1'b0);
        repeat (3) step(1'b1);
        check("short_wait", {6'b0, mode}, 8'h00);
        step(1'b1);
        check("short_mode", {6'b0, mode}, 8'h01);
        check("short_ledx", ledx, 8'hFE);
        check("short_paused", {7'b0, paused}, 8'h01);
        repeat (30) step(1'b0);
        check("unpause", {7'b0, paused}, 8'h00);
        repeat (20) step(1'b1);
        check("resume_mode", {6'b0, mode}, 8'h01);
`endif

        repeat (6) step(1'b1);
        lvl = 1'b1;
        for (int s = 0; s < 40; s++) begin
            lvl = !lvl;
            repeat ($urandom_range(1, 30)) step(lvl);
        end
        repeat (10) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
